frame_capture_ctrl: RTL and testbench

Capture controller for the pixel-stream front end of the vision pipeline. Monitors the parallel RGB stream (data enable, horizontal sync, vertical sync, 24-bit pixel), and on a software/FSM request grabs exactly one complete frame. The frame is written as a linear address/data sequence into a downstream frame buffer. It also checks frame geometry, reports errors, and keeps a free-running frame counter for the rest of the pipeline.

---
 rtl/frame_capture_ctrl.sv | 144 ++++++++++++++
 tb/tb_frame_capture_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: single-frame grabber for the parallel RGB pixel stream.
// Arms on start, begins writing at the next vsync rising edge, and streams
// exactly H_RES*V_RES pixels to a linear frame buffer. Flags line-length and
// early-vsync geometry errors. Also keeps a free-running frame counter.
module frame_capture_ctrl #(
  parameter int H_RES  = 64,
  parameter int V_RES  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_de,
  input  logic              in_hs,
  input  logic              in_vs,
  input  logic [7:0]        in_r,
  input  logic [7:0]        in_g,
  input  logic [7:0]        in_b,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic [7:0]        frame_cnt
);

  localparam int              TOTAL    = H_RES * V_RES;
  localparam logic [ADDR_W:0] LAST_PIX = (ADDR_W + 1)'(TOTAL - 1);
  localparam logic [10:0]     LINE_LEN = 11'(H_RES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t          state;
  logic            vs_q;
  logic            de_q;
  logic [10:0]     x;
  logic [ADDR_W:0] pix;
  logic            vs_rise;
  logic            de_fall;
  logic            line_bad;
  logic            unused_hs;

  // Horizontal sync carries no information the capture logic needs; line
  // boundaries come from data-enable edges instead.
  assign unused_hs = in_hs;

  assign vs_rise  = in_vs & ~vs_q;
  assign de_fall  = ~in_de & de_q;
  assign line_bad = de_fall && (x != LINE_LEN);

  // Sync edge history and free-running frame counter (counts every vsync rise).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      vs_q <= in_vs;
      de_q <= in_de;
      if (vs_rise) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Active-pixel count within the current line; frame start realigns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= 11'd0;
    end else if (vs_rise) begin
      x <= 11'd0;
    end else if (in_de) begin
      x <= x + 11'd1;
    end else if (de_q) begin
      x <= 11'd0;
    end
  end

  // Capture FSM with registered status and buffer-write outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 24'd0;
      pix     <= '0;
    end else begin
      done  <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          // Abort in the same cycle cancels the request outright.
          if (start && !abort) begin
            state <= ARM;
            busy  <= 1'b1;
            err   <= 1'b0;
          end
        end
        ARM: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (vs_rise) begin
            state <= CAPT;
            pix   <= '0;
          end
        end
        CAPT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (vs_rise || line_bad) begin
            // Any vsync rise here means the frame ended before the last pixel.
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else if (in_de) begin
            wr_en   <= 1'b1;
            wr_addr <= pix[ADDR_W-1:0];
            wr_data <= {in_r, in_g, in_b};
            pix     <= pix + 1'b1;
            if (pix == LAST_PIX) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl: synthetic 64x64 video timing with random pixels.
// The stimulus decides from the scenario which pixels must land in the buffer
// and queues them; an independent monitor pops and compares every write.
module tb_frame_capture_ctrl;

  localparam int H_RES  = 64;
  localparam int V_RES  = 64;
  localparam int ADDR_W = 12;
  localparam int TOTAL  = H_RES * V_RES;
  localparam int HS_W   = 2;
  localparam int HBP    = 8;
  localparam int HFP    = 8;
  localparam int LINE   = HS_W + HBP + H_RES + HFP;
  localparam int VBLANK = 5;
  localparam int VS_L   = 4;

  logic              clk;
  logic              rst_n;
  logic              in_de, in_hs, in_vs;
  logic [7:0]        in_r, in_g, in_b;
  logic              start, abort;
  logic              busy, done, err, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic [7:0]        frame_cnt;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [23:0]       data;
    logic              last;
  } wr_t;

  wr_t exp_q[$];
  wr_t got;
  int  checks   = 0;
  int  failures = 0;
  int  done_cnt = 0;
  int  vs_cnt   = 0;

  frame_capture_ctrl #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor: every buffer write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      checks++;
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write actual=addr %0d data %06h required=no write", wr_addr, wr_data);
        end else begin
          got = exp_q.pop_front();
          if (wr_addr !== got.addr || wr_data !== got.data || done !== got.last) begin
            failures++;
            $display("FAIL write actual=addr %0d data %06h done %0b required=addr %0d data %06h done %0b",
                     wr_addr, wr_data, done, got.addr, got.data, got.last);
          end
        end
      end else if (done !== 1'b0) begin
        failures++;
        $display("FAIL done_without_write actual=%0b required=0", done);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit de, input bit hs, input bit vs, input logic [23:0] px);
    in_de = de;
    in_hs = hs;
    in_vs = vs;
    {in_r, in_g, in_b} = px;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    chk("busy_before_start", {31'd0, busy}, 32'd0);
    start = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 24'd0);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("err_cleared_by_start", {31'd0, err}, 32'd0);
  endtask

  // One frame: vertical blanking with vsync, then `lines` active lines.
  // The first cap_n active pixels are expected in the buffer; cap_done marks
  // the final one as carrying the done pulse.
  task automatic run_frame(input int lines, input int short_line, input int start_line,
                           input int cap_n, input bit cap_done, input int abort_at,
                           input int rst_at);
    int npix;
    npix = 0;
    for (int l = 0; l < VBLANK; l++) begin
      for (int c = 0; c < LINE; c++) begin
        if (l == 0 && c == 0) vs_cnt++;
        cyc(1'b0, c < HS_W, l < VS_L, 24'd0);
      end
    end
    for (int l = 0; l < lines; l++) begin
      for (int c = 0; c < LINE; c++) begin
        int          w;
        bit          de;
        bit          did_abort;
        logic [23:0] px;
        wr_t         e;
        w  = (l == short_line) ? H_RES - 1 : H_RES;
        de = (c >= HS_W + HBP) && (c < HS_W + HBP + w);
        px = de ? 24'($urandom) : 24'd0;
        did_abort = 1'b0;
        if (l == start_line && c == 0) start = 1'b1;
        if (de) begin
          if (npix == abort_at) begin
            abort = 1'b1;
            did_abort = 1'b1;
          end else if (npix < cap_n) begin
            e.addr = ADDR_W'(npix);
            e.data = px;
            e.last = cap_done && (npix == cap_n - 1);
            exp_q.push_back(e);
          end
          npix++;
        end
        cyc(de, c < HS_W, 1'b0, px);
        start = 1'b0;
        abort = 1'b0;
        if (did_abort) begin
          chk("abort_busy", {31'd0, busy}, 32'd0);
          chk("abort_wr_en", {31'd0, wr_en}, 32'd0);
          chk("abort_done", {31'd0, done}, 32'd0);
        end
        if (l == short_line && c == HS_W + HBP + w - 1)
          chk("short_err_before_fall", {31'd0, err}, 32'd0);
        if (l == short_line && c == HS_W + HBP + w) begin
          chk("short_err_after_fall", {31'd0, err}, 32'd1);
          chk("short_busy_after_fall", {31'd0, busy}, 32'd0);
        end
        if (de && npix == rst_at) begin
          in_de = 1'b0;
          @(negedge clk);
          #1;
          chk("writes_before_reset", exp_q.size(), 32'd0);
          rst_n = 1'b0;
          #1;
          chk("rst_busy", {31'd0, busy}, 32'd0);
          chk("rst_done", {31'd0, done}, 32'd0);
          chk("rst_err", {31'd0, err}, 32'd0);
          chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
          chk("rst_wr_addr", 32'(wr_addr), 32'd0);
          chk("rst_wr_data", 32'(wr_data), 32'd0);
          chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
          exp_q.delete();
          vs_cnt = 0;
          return;
        end
      end
    end
  endtask

  task automatic end_checks(input string tag, input bit exp_busy, input bit exp_err,
                            input int exp_done);
    chk({tag, "_queue_drained"}, exp_q.size(), 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, "_done_count"}, done_cnt, exp_done);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), vs_cnt % 256);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    in_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0;
    in_r = 8'd0; in_g = 8'd0; in_b = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_wr_en", {31'd0, wr_en}, 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_wr_data", 32'(wr_data), 32'd0);
    chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 24'd0);

    // Nominal: start mid-frame, nothing written until the next frame.
    done_cnt = 0;
    run_frame(V_RES, -1, 30, 0, 1'b0, -1, -1);
    end_checks("armed", 1'b1, 1'b0, 0);
    run_frame(V_RES, -1, -1, TOTAL, 1'b1, -1, -1);
    end_checks("nominal", 1'b0, 1'b0, 1);

    // Short line 10: 640 + 63 writes, then error.
    done_cnt = 0;
    pulse_start();
    run_frame(V_RES, 10, -1, 10 * H_RES + H_RES - 1, 1'b0, -1, -1);
    end_checks("short_line", 1'b0, 1'b1, 0);

    // Early vsync after 30 lines, then a clean recapture.
    done_cnt = 0;
    pulse_start();
    run_frame(30, -1, -1, 30 * H_RES, 1'b0, -1, -1);
    end_checks("early_pending", 1'b1, 1'b0, 0);
    run_frame(0, -1, -1, 0, 1'b0, -1, -1);
    end_checks("early_vs", 1'b0, 1'b1, 0);
    pulse_start();
    run_frame(V_RES, -1, -1, TOTAL, 1'b1, -1, -1);
    end_checks("recapture", 1'b0, 1'b0, 1);

    // Abort at pix=100, then start+abort together from idle.
    done_cnt = 0;
    pulse_start();
    run_frame(3, -1, -1, 100, 1'b0, 100, -1);
    end_checks("abort", 1'b0, 1'b0, 0);
    start = 1'b1;
    abort = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 24'd0);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", {31'd0, busy}, 32'd0);
    run_frame(2, -1, -1, 0, 1'b0, -1, -1);
    end_checks("start_abort", 1'b0, 1'b0, 0);

    // Asynchronous reset at pix=2000, then 300 vsync pulses.
    pulse_start();
    run_frame(V_RES, -1, -1, TOTAL, 1'b1, -1, 2000);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 24'd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 24'd0);
    for (int i = 0; i < 300; i++) begin
      vs_cnt++;
      cyc(1'b0, 1'b0, 1'b1, 24'd0);
      cyc(1'b0, 1'b0, 1'b0, 24'd0);
    end
    cyc(1'b0, 1'b0, 1'b0, 24'd0);
    chk("frame_cnt_wrap", 32'(frame_cnt), 32'd44);
    chk("frame_cnt_model", 32'(frame_cnt), vs_cnt % 256);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    chk("post_reset_queue", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
